// File: rtl/vram_scroll.sv
// vram_scroll: character-cell video RAM with a circular vertical scroll offset.
//
// A DEPTH = COLS*ROWS cell memory. A windowed write port maps the addresses
// WIN_BASE .. WIN_BASE+DEPTH-1 onto cells 0 .. DEPTH-1. A logical
// (row, column) read port adds the scroll offset to the row, wrapping modulo
// ROWS. A clear engine sweeps FILL into every cell, one cell per cycle. It
// runs after reset and on clear_req.
//
// Optional feature: define VRAM_SCROLL_EN to build the scroll register and the
// row-offset adder. Without it, the scroll_we/scroll_row inputs are ignored and
// the physical row equals rd_row.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   rd_en/rd_col/rd_row read request at a logical cell
//   rd_data/rd_valid    registered read result, valid one cycle after rd_en
//   wr_en/wr_addr/      write request into the address window
//   wr_data
//   wr_ack/wr_err       one-cycle pulses: write accepted / address outside window
//   scroll_we/          load the top-row offset (values >= ROWS are ignored)
//   scroll_row
//   clear_req           start a full clear sweep
//   busy                clear sweep in progress (also high during reset)
module vram_scroll #(
  parameter int unsigned          DATA_W   = 8,
  parameter int unsigned          COLS     = 80,
  parameter int unsigned          ROWS     = 30,
  parameter int unsigned          WADDR_W  = 16,
  parameter int unsigned          WIN_BASE = 0,
  parameter logic [DATA_W-1:0]    FILL     = '0,
  localparam int unsigned         DEPTH    = COLS * ROWS,
  localparam int unsigned         COL_W    = $clog2(COLS),
  localparam int unsigned         ROW_W    = $clog2(ROWS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic [COL_W-1:0]   rd_col,
  input  logic [ROW_W-1:0]   rd_row,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_valid,
  input  logic               wr_en,
  input  logic [WADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  output logic               wr_ack,
  output logic               wr_err,
  input  logic               scroll_we,
  input  logic [ROW_W-1:0]   scroll_row,
  input  logic               clear_req,
  output logic               busy
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  // The limits are one bit wider than the fields so that COLS/ROWS fit even
  // when they are exact powers of two.
  localparam logic [COL_W:0]    ColsW    = (COL_W + 1)'(COLS);
  localparam logic [ROW_W:0]    RowsW    = (ROW_W + 1)'(ROWS);
  localparam logic [WADDR_W:0]  WinLo    = (WADDR_W + 1)'(WIN_BASE);
  localparam logic [WADDR_W:0]  WinHi    = (WADDR_W + 1)'(WIN_BASE + DEPTH);
  localparam logic [ADDR_W-1:0] LastCell = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                clr_we;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_valid_q;
  logic                wr_ack_q;
  logic                wr_err_q;

  logic                in_win;
  logic                wr_open;
  logic                wr_accept;
  logic                wr_reject;
  logic [ADDR_W-1:0]   wr_cell;

  logic                rd_ok;
  logic [ROW_W-1:0]    prow;
  logic [ADDR_W-1:0]   rd_cell;

  assign busy = rst | (state_q == StClear);

  // ---------------------------------------------------------------------------
  // Clear FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clear_req) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        clr_we = 1'b1;
        if (cnt_q == LastCell) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Reset parks the FSM in CLEAR at cell 0. The sweep starts on the first
  // cycle after rst deasserts, and it restarts from 0 if rst pulses mid-sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Write port
  // ---------------------------------------------------------------------------
  assign in_win    = ({1'b0, wr_addr} >= WinLo) && ({1'b0, wr_addr} < WinHi);
  // A clear starting this cycle overwrites everything anyway, so a write that
  // coincides with clear_req is dropped as if busy were already high.
  assign wr_open   = wr_en && !busy && !clear_req;
  assign wr_accept = wr_open && in_win;
  assign wr_reject = wr_open && !in_win;
  assign wr_cell   = ADDR_W'(wr_addr - WADDR_W'(WIN_BASE));

  // The clear sweep and user writes are mutually exclusive, because user
  // writes need busy=0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        mem[cnt_q] <= FILL;
      end else if (wr_accept) begin
        mem[wr_cell] <= wr_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scroll offset and read address
  // ---------------------------------------------------------------------------
`ifdef VRAM_SCROLL_EN
  logic [ROW_W-1:0] scroll_q;
  logic [ROW_W:0]   row_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      scroll_q <= '0;
    end else if (scroll_we && ({1'b0, scroll_row} < RowsW)) begin
      scroll_q <= scroll_row;
    end
  end

  // Both operands are < ROWS on valid reads, so one conditional subtract
  // wraps the sum. Invalid rows are masked to FILL below.
  always_comb begin
    row_sum = {1'b0, rd_row} + {1'b0, scroll_q};
    if (row_sum >= RowsW) begin
      prow = ROW_W'(row_sum - RowsW);
    end else begin
      prow = row_sum[ROW_W-1:0];
    end
  end
`else
  logic unused_scroll;
  assign unused_scroll = scroll_we ^ (^scroll_row);
  assign prow          = rd_row;
`endif

  assign rd_ok   = ({1'b0, rd_col} < ColsW) && ({1'b0, rd_row} < RowsW);
  assign rd_cell = ADDR_W'(prow) * ADDR_W'(COLS) + ADDR_W'(rd_col);

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  // The read samples mem before this edge's write lands. A same-cycle read
  // of a cell that is being written therefore returns the old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= FILL;
      rd_valid_q <= 1'b0;
      wr_ack_q   <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_q <= (busy || !rd_ok) ? FILL : mem[rd_cell];
      end
      wr_ack_q <= wr_accept;
      wr_err_q <= wr_reject;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign wr_ack   = wr_ack_q;
  assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_vram_scroll.sv
// Self-checking bench for vram_scroll (COLS=80, ROWS=30, WIN_BASE=0, FILL=0).
// Read expectations come from a behavioural model of the cell array and the
// scroll offset. They are queued when a read is driven and compared when
// rd_valid appears.
module tb_vram_scroll;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int DEPTH = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en;
  logic [6:0]  rd_col;
  logic [4:0]  rd_row;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic        wr_err;
  logic        scroll_we;
  logic [4:0]  scroll_row;
  logic        clear_req;
  logic        busy;

  always #5 clk = ~clk;

  vram_scroll #(
    .DATA_W   (8),
    .COLS     (COLS),
    .ROWS     (ROWS),
    .WADDR_W  (16),
    .WIN_BASE (0),
    .FILL     (8'h00)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .rd_col     (rd_col),
    .rd_row     (rd_row),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .scroll_we  (scroll_we),
    .scroll_row (scroll_row),
    .clear_req  (clear_req),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] data;
    int         due;
  } rd_exp_t;

  rd_exp_t    sb[$];
  logic [7:0] model_mem [DEPTH];
  int         scroll_m = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [7:0] exp_read(input int row, input int col);
    int prow;
    if (col >= COLS || row >= ROWS) return 8'h00;
`ifdef VRAM_SCROLL_EN
    prow = (row + scroll_m) % ROWS;
`else
    prow = row;
`endif
    return model_mem[prow * COLS + col];
  endfunction

  // Read monitor: every rd_valid must match the oldest queued expectation,
  // and it must arrive exactly one cycle after the read was driven.
  always @(negedge clk) begin : monitor
    rd_exp_t e;
    if (!rst && rd_valid) begin
      if (sb.size() == 0) begin
        check_eq("rd_valid_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("rd_data", 32'(rd_data), 32'(e.data));
        check_eq("rd_latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  // All tasks start and end just after a falling edge.
  task automatic drive_read(input int row, input int col);
    rd_en  = 1'b1;
    rd_row = 5'(row);
    rd_col = 7'(col);
    sb.push_back('{exp_read(row, col), cyc + 1});
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic do_write(input int addr, input logic [7:0] data);
    logic exp_in;
    exp_in  = (addr < DEPTH);
    wr_en   = 1'b1;
    wr_addr = 16'(addr);
    wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    check_eq("wr_ack", 32'(wr_ack), 32'(exp_in));
    check_eq("wr_err", 32'(wr_err), 32'(!exp_in));
    if (exp_in) model_mem[addr] = data;
  endtask

  task automatic set_scroll(input int v);
    scroll_we  = 1'b1;
    scroll_row = 5'(v);
    @(negedge clk);
    scroll_we = 1'b0;
`ifdef VRAM_SCROLL_EN
    if (v < ROWS) scroll_m = v;
`endif
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 3000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
  endtask

  task automatic sweep();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        drive_read(r, c);
    repeat (2) @(negedge clk);
  endtask

  initial begin : stim
    int n;
    rst        = 1'b1;
    rd_en      = 1'b0;
    rd_col     = '0;
    rd_row     = '0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    scroll_we  = 1'b0;
    scroll_row = '0;
    clear_req  = 1'b0;
    model_clear();

    // Reset state, with read and write requests held to show they are ignored.
    repeat (2) @(negedge clk);
    rd_en   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 16'd3;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd1);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_rd_data", 32'(rd_data), 32'd0);
    check_eq("rst_wr_ack", 32'(wr_ack), 32'd0);
    check_eq("rst_wr_err", 32'(wr_err), 32'd0);
    rd_en = 1'b0;
    wr_en = 1'b0;
    rst   = 1'b0;

    // Post-reset sweep length.
    count_busy(n);
    check_eq("busy_after_reset", 32'(n), 32'd2400);
    drive_read(0, 0);

    // Windowed write and read back; rd_data must hold while rd_en=0.
    do_write(16'h0051, 8'hA5);
    drive_read(1, 1);
    @(negedge clk);
    check_eq("rd_hold_data", 32'(rd_data), 32'hA5);
    check_eq("rd_hold_valid", 32'(rd_valid), 32'd0);

    // Out-of-window writes are rejected.
    do_write(2400, 8'h33);
    do_write(16'hFFFF, 8'h33);

    // Same-cycle write and read of one cell returns the old contents.
    do_write(5, 8'h11);
    wr_en   = 1'b1;
    wr_addr = 16'd5;
    wr_data = 8'h22;
    drive_read(0, 5);
    wr_en = 1'b0;
    check_eq("wr_ack_same_cycle", 32'(wr_ack), 32'd1);
    model_mem[5] = 8'h22;
    drive_read(0, 5);

    // Out-of-range reads return FILL even when they alias written cells.
    do_write(0, 8'h0A);
    do_write(80, 8'h5C);
    drive_read(0, 80);
    drive_read(0, 127);
    drive_read(30, 0);
    drive_read(31, 5);

    // Scroll offset, including ignored out-of-range loads.
    do_write(1, 8'h77);
    do_write(81, 8'h81);
    do_write(2320, 8'h2D);
    do_write(2399, 8'h99);
    set_scroll(29);
    drive_read(1, 1);
    set_scroll(30);
    drive_read(1, 1);
    set_scroll(31);
    drive_read(0, 0);
    drive_read(29, 79);
    sweep();

    // clear_req with a simultaneous write: the write is dropped and the
    // sweep runs. A read, a write and another clear_req are issued mid-sweep.
    set_scroll(0);
    clear_req = 1'b1;
    wr_en     = 1'b1;
    wr_addr   = 16'd10;
    wr_data   = 8'h5A;
    @(negedge clk);
    clear_req = 1'b0;
    wr_en     = 1'b0;
    check_eq("clear_wr_ack", 32'(wr_ack), 32'd0);
    check_eq("clear_wr_err", 32'(wr_err), 32'd0);
    n = 0;
    while (busy && n < 3000) begin
      n++;
      if (n == 5) begin
        rd_en     = 1'b1;
        rd_row    = 5'd29;
        rd_col    = 7'd79;
        sb.push_back('{8'h00, cyc + 1});
        wr_en     = 1'b1;
        wr_addr   = 16'd20;
        wr_data   = 8'h44;
        clear_req = 1'b1;
      end else if (n == 6) begin
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        clear_req = 1'b0;
        check_eq("busy_wr_ack", 32'(wr_ack), 32'd0);
        check_eq("busy_wr_err", 32'(wr_err), 32'd0);
      end
      @(negedge clk);
    end
    check_eq("busy_after_clear", 32'(n), 32'd2400);
    model_clear();
    sweep();

    // Reset mid-sweep restarts the sweep and resets the scroll offset.
    set_scroll(5);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    scroll_m = 0;
    count_busy(n);
    check_eq("busy_after_mid_reset", 32'(n), 32'd2400);
    model_clear();
    do_write(0, 8'hE1);
    drive_read(0, 0);
    drive_read(0, 7);

    repeat (3) @(negedge clk);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_scroll.md
VRAM_SCROLL -- requirements
Module: vram_scroll

Interface
REQ-001 SHALL have parameter DATA_W, default 8, cell width in bits.
REQ-002 SHALL have parameter COLS, default 80, character columns.
REQ-003 SHALL have parameter ROWS, default 30, character rows.
REQ-004 SHALL have parameter WADDR_W, default 16, write-address width.
REQ-005 SHALL have parameter WIN_BASE, default 0, first write address mapped to cell 0.
REQ-006 SHALL have parameter FILL, default 0, value written by clear and returned for invalid reads.
REQ-007 SHALL derive DEPTH=COLS*ROWS, COL_W=$clog2(COLS), ROW_W=$clog2(ROWS).
REQ-008 SHALL have ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- rd_en  in  1  read request.
- rd_col  in  COL_W  logical column.
- rd_row  in  ROW_W  logical row.
- rd_data  out  DATA_W  read result.
- rd_valid  out  1  rd_data updated this cycle.
- wr_en  in  1  write request.
- wr_addr  in  WADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_ack  out  1  write accepted.
- wr_err  out  1  write address outside window.
- scroll_we  in  1  load scroll register.
- scroll_row  in  ROW_W  new top-row offset.
- clear_req  in  1  start full clear.
- busy  out  1  clear in progress.

Function
REQ-009 SHALL accept a write when wr_en=1, busy=0 and WIN_BASE<=wr_addr<WIN_BASE+DEPTH; stores wr_data at cell wr_addr-WIN_BASE; wr_ack=1 the following cycle.
REQ-010 SHALL drop an out-of-window write when busy=0; wr_err=1 the following cycle; no ack, memory unchanged.
REQ-011 SHALL drop writes while busy=1, with wr_ack=0 and wr_err=0.
REQ-012 SHALL compute physical row = rd_row+scroll; subtract ROWS once if the sum >= ROWS (no divider); cell = prow*COLS+rd_col.
REQ-013 SHALL register the read result one cycle after rd_en=1; rd_valid pulses that cycle; rd_data holds its value when rd_en=0.
REQ-014 SHALL return FILL for a read with rd_col>=COLS or rd_row>=ROWS.
REQ-015 SHALL return old contents when a read and an accepted write target the same cell in the same cycle.
REQ-016 SHALL load the scroll register from scroll_row on scroll_we when scroll_row<ROWS; values >=ROWS SHALL be ignored; new value applies to reads issued the next cycle.
REQ-017 SHALL implement FSM IDLE/CLEAR: IDLE->CLEAR on clear_req; CLEAR writes FILL at counter 0..DEPTH-1, one cell per cycle; after cell DEPTH-1, CLEAR->IDLE.
REQ-018 SHALL assert busy exactly while in CLEAR; clear_req in CLEAR SHALL be ignored.
REQ-019 SHALL, during CLEAR, still serve reads with rd_valid pulses but rd_data=FILL.

Reset
REQ-020 SHALL, while rst=1: FSM=CLEAR, counter=0, busy=1, rd_data=FILL, rd_valid=0, wr_ack=0, wr_err=0, scroll=0.
REQ-021 SHALL begin the clear sweep on the first cycle after rst deasserts; busy stays high DEPTH cycles.
REQ-022 SHALL restart the sweep from 0 on rst asserted mid-clear.

Configuration
REQ-023 SHALL, with VRAM_SCROLL_EN defined, include the scroll register and row-offset adder per REQ-012 and REQ-016.
REQ-024 SHALL, without VRAM_SCROLL_EN, omit the scroll register, ignore scroll_we/scroll_row and use physical row = rd_row.

Verification (COLS=80, ROWS=30, WIN_BASE=0, FILL=0)
REQ-025 Reset release -> busy high exactly 2400 cycles; then read (row0,col0) -> rd_data=0x00, rd_valid one cycle later.
REQ-026 Write addr 0x0051 data 0xA5 -> wr_ack next cycle; read row1 col1 -> 0xA5.
REQ-027 Write addr 2400 data 0x33 -> wr_err pulse, no wr_ack; full read sweep -> no cell equals 0x33.
REQ-028 Write addr 1 = 0x77, scroll_row=29, read row1 col1 -> 0x77 (macro on); macro off -> value at cell 81.
REQ-029 clear_req with simultaneous wr_en addr 10 -> write dropped, busy 2400 cycles, all cells read 0x00.
REQ-030 Cell 5 = 0x11, same-cycle write 0x22 and read cell 5 -> 0x11; next read -> 0x22.
